hash_cash_ctrl: RTL and testbench
=================================

Name: hash_cash_ctrl

Overview:
- Sequencer and round-robin arbiter in front of one hash_cash instance; shares it between NUM_REQ requesters.
- Every operation is a LOOKUP followed by an optional COMMIT. This guarantees no duplicate-key writes, no writes into a full cache, and deletes only of present keys.
- Tracks cache occupancy and returns a status plus read data per transaction.

Parameters:
- DATA_WIDTH, 32, data word width; matches hash_cash.
- KEY_WIDTH, 32, key width; matches hash_cash.
- MEM_SIZE, 128, number of cache entries; sets the occupancy limit.
- NUM_REQ, 2, number of requesters (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept. A transfer happens when valid&ready.
- req_op  in  NUM_REQ x 2  op per requester: 0=READ, 1=WRITE, 2=DELETE, 3=reserved (treated as READ).
- req_key  in  NUM_REQ x KEY_WIDTH  key per requester.
- req_data  in  NUM_REQ x DATA_WIDTH  write data per requester.
- resp_valid  out  NUM_REQ  one-cycle pulse to the owning requester.
- resp_status  out  2  0=OK, 1=MISS, 2=DUP, 3=FULL.
- resp_data  out  DATA_WIDTH  read data; valid with resp_valid on READ+OK, otherwise 0.
- occupancy  out  $clog2(MEM_SIZE+1)  live entry count.
- cache_cs, cache_we, cache_read_en, cache_del  out  1  hash_cash controls.
- cache_key_write, cache_key_read  out  KEY_WIDTH  hash_cash keys.
- cache_data_in  out  DATA_WIDTH  hash_cash write data.
- cache_data_out  in  DATA_WIDTH  hash_cash registered data.
- cache_valid  in  1  hash_cash valid_o.
- cache_error  in  2  hash_cash error.

Behaviour:
- Reset (async, active-high):
  - State IDLE, rr pointer 0, occupancy 0.
  - All outputs 0, including req_ready, resp_valid and all cache_* outputs.
  - Reset mid-operation drops the transaction; no response is issued.
- FSM: IDLE -> LOOKUP -> EVAL -> {COMMIT ->} RESP -> IDLE.
- IDLE:
  - The rr arbiter picks the first valid requester at or after the pointer.
  - req_ready is one-hot to the winner, combinational, IDLE only.
  - On transfer: latch op/key/data/owner, advance the pointer to owner+1 mod NUM_REQ, go to LOOKUP.
- LOOKUP:
  - Drive cache_cs=1, cache_read_en=1, cache_key_read=key; go to EVAL.
- EVAL:
  - cache_cs=0, so the cache holds its outputs.
  - hit = cache_valid.
  - READ: status OK if hit (capture cache_data_out), else MISS; go to RESP.
  - WRITE with hit: status DUP; go to RESP.
  - WRITE with occupancy==MEM_SIZE: status FULL; go to RESP.
  - WRITE otherwise: go to COMMIT.
  - DELETE with hit: go to COMMIT. DELETE without hit: status MISS; go to RESP.
- COMMIT:
  - Drive cache_cs=1, cache_key_write=key, plus cache_we=1 and cache_data_in=data (WRITE) or cache_del=1 (DELETE).
  - WRITE: occupancy+1, status OK. If cache_error[0]=1 in this cycle, status DUP and no increment.
  - DELETE: occupancy-1, status OK.
  - Go to RESP.
- RESP:
  - resp_valid[owner]=1 for exactly one cycle; resp_status/resp_data are held stable this cycle, 0 otherwise.
  - Then go to IDLE.
- Latency from accept to response: READ / miss-type outcomes 3 cycles, COMMIT paths 4 cycles.
- One transaction in flight; back-to-back accepts are possible the cycle after RESP.
- Occupancy saturates and never wraps; it is guarded by the FULL check and hit-only deletes.
- cache_key_read/key_write hold the latched key throughout the transaction; 0 in IDLE.

Optional Feature:
- Macro HASH_CASH_CTRL_STATS_EN.
- Defined: adds outputs stat_hits and stat_misses (32 bits each), plus stat_clear (input, 1). Counters saturate at all-ones.
  - stat_hits increments in EVAL when cache_valid=1.
  - stat_misses increments in EVAL when cache_valid=0.
  - Both reset to 0 and clear synchronously on stat_clear; clear wins over a same-cycle increment.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hash_cash_ctrl_pkg:
  - op_e (READ/WRITE/DELETE/RSVD).
  - status_e (OK/MISS/DUP/FULL).
  - state_e (IDLE/LOOKUP/EVAL/COMMIT/RESP).
- Sub-module rr_arbiter (parameter NUM_REQ): inputs req vector, pointer, enable; outputs one-hot grant and grant index.

Test Plan:
- Reset, then WRITE key 0x10 data 0xAB from req0 -> resp_status OK after 4 cycles, occupancy 1. READ key 0x10 -> OK, resp_data 0xAB after 3 cycles.
- WRITE 0x10 again -> DUP, no cache_we pulse, occupancy stays 1. READ 0x99 -> MISS, resp_data 0.
- DELETE 0x10 -> OK, cache_del pulse, occupancy 0. DELETE 0x10 again -> MISS, no cache_del.
- MEM_SIZE=4: write keys 1..4 -> all OK, occupancy 4. Write key 5 -> FULL, no cache_we.
- NUM_REQ=2, both valid continuously with READ -> grants alternate 0,1,0,1. Each resp_valid goes only to its owner.
- Assert reset during COMMIT -> all outputs 0 immediately, no resp_valid. After release, occupancy 0 and the next request is served normally.

Source files
------------

// File: rtl/hash_cash_ctrl_pkg.sv
// Shared types for the hash_cash sequencer: op codes, response status and FSM states.
package hash_cash_ctrl_pkg;

   typedef enum logic [1:0] {
      READ   = 2'd0,
      WRITE  = 2'd1,
      DELETE = 2'd2,
      RSVD   = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      OK   = 2'd0,
      MISS = 2'd1,
      DUP  = 2'd2,
      FULL = 2'd3
   } status_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      EVAL   = 3'd2,
      COMMIT = 3'd3,
      RESP   = 3'd4
   } state_e;

   // Index width that stays legal for a single requester
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hash_cash_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter
   import hash_cash_ctrl_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
         if (enable && !found && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hash_cash_ctrl.sv
// Sequencer/arbiter sharing one hash_cash between NUM_REQ requesters (lookup, then optional commit).
// Optional hit/miss statistics counters are enabled with macro HASH_CASH_CTRL_STATS_EN.
module hash_cash_ctrl
   import hash_cash_ctrl_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 32,
   parameter  int unsigned KEY_WIDTH  = 32,
   parameter  int unsigned MEM_SIZE   = 128,
   parameter  int unsigned NUM_REQ    = 2,
   localparam int unsigned OCC_W      = $clog2(MEM_SIZE + 1),
   localparam int unsigned IDX_W      = idx_width(NUM_REQ)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ-1:0][1:0]              req_op,
   input  logic [NUM_REQ-1:0][KEY_WIDTH-1:0]    req_key,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]                   resp_valid,
   output logic [1:0]                           resp_status,
   output logic [DATA_WIDTH-1:0]                resp_data,
   output logic [OCC_W-1:0]                     occupancy,
   output logic                                 cache_cs,
   output logic                                 cache_we,
   output logic                                 cache_read_en,
   output logic                                 cache_del,
   output logic [KEY_WIDTH-1:0]                 cache_key_write,
   output logic [KEY_WIDTH-1:0]                 cache_key_read,
   output logic [DATA_WIDTH-1:0]                cache_data_in,
   input  logic [DATA_WIDTH-1:0]                cache_data_out,
   input  logic                                 cache_valid,
   input  logic [1:0]                           cache_error
`ifdef HASH_CASH_CTRL_STATS_EN
   ,
   input  logic                                 stat_clear,
   output logic [31:0]                          stat_hits,
   output logic [31:0]                          stat_misses
`endif
);

   state_e                state;
   op_e                   op;
   logic [DATA_WIDTH-1:0] data;
   logic [IDX_W-1:0]      owner;
   logic [IDX_W-1:0]      ptr;
   logic [NUM_REQ-1:0]    grant;
   logic [IDX_W-1:0]      gidx;
   logic                  full;
   logic                  unused;

   assign unused = cache_error[1];
   assign full   = (occupancy == OCC_W'(MEM_SIZE));

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .enable    ((state == IDLE) && !reset),
      .grant     (grant),
      .grant_idx (gidx)
   );

   assign req_ready = grant;

   // Transaction sequencer; all cache controls and responses are registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         op              <= READ;
         data            <= '0;
         owner           <= '0;
         ptr             <= '0;
         occupancy       <= '0;
         resp_valid      <= '0;
         resp_status     <= '0;
         resp_data       <= '0;
         cache_cs        <= 1'b0;
         cache_we        <= 1'b0;
         cache_read_en   <= 1'b0;
         cache_del       <= 1'b0;
         cache_key_write <= '0;
         cache_key_read  <= '0;
         cache_data_in   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  op              <= op_e'(req_op[gidx]);
                  data            <= req_data[gidx];
                  owner           <= gidx;
                  ptr             <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);
                  cache_cs        <= 1'b1;
                  cache_read_en   <= 1'b1;
                  cache_key_read  <= req_key[gidx];
                  cache_key_write <= req_key[gidx];
                  state           <= LOOKUP;
               end
            end
            LOOKUP: begin
               cache_cs      <= 1'b0;
               cache_read_en <= 1'b0;
               state         <= EVAL;
            end
            EVAL: begin
               // Default: answer directly; commit paths override below
               state      <= RESP;
               resp_valid <= NUM_REQ'(1) << owner;
               case (op)
                  WRITE: begin
                     if (cache_valid) begin
                        resp_status <= DUP;
                     end else if (full) begin
                        resp_status <= FULL;
                     end else begin
                        resp_valid    <= '0;
                        cache_cs      <= 1'b1;
                        cache_we      <= 1'b1;
                        cache_data_in <= data;
                        state         <= COMMIT;
                     end
                  end
                  DELETE: begin
                     if (cache_valid) begin
                        resp_valid <= '0;
                        cache_cs   <= 1'b1;
                        cache_del  <= 1'b1;
                        state      <= COMMIT;
                     end else begin
                        resp_status <= MISS;
                     end
                  end
                  default: begin
                     resp_status <= cache_valid ? OK : MISS;
                     resp_data   <= cache_valid ? cache_data_out : '0;
                  end
               endcase
            end
            COMMIT: begin
               cache_cs      <= 1'b0;
               cache_we      <= 1'b0;
               cache_del     <= 1'b0;
               cache_data_in <= '0;
               resp_valid    <= NUM_REQ'(1) << owner;
               state         <= RESP;
               if (op == WRITE) begin
                  if (cache_error[0]) begin
                     resp_status <= DUP;
                  end else begin
                     resp_status <= OK;
                     if (!full) occupancy <= occupancy + OCC_W'(1);
                  end
               end else begin
                  resp_status <= OK;
                  if (occupancy != '0) occupancy <= occupancy - OCC_W'(1);
               end
            end
            RESP: begin
               resp_valid      <= '0;
               resp_status     <= '0;
               resp_data       <= '0;
               cache_key_read  <= '0;
               cache_key_write <= '0;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HASH_CASH_CTRL_STATS_EN
   // Saturating lookup hit/miss counters; clear beats a same-cycle increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else if (stat_clear) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else if (state == EVAL) begin
         if (cache_valid) begin
            if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
         end else begin
            if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hash_cash_ctrl.sv
// Bench for hash_cash_ctrl: behavioural cache, key/value reference map and round-robin model.
module tb_hash_cash_ctrl;

   localparam int unsigned DW    = 32;
   localparam int unsigned KW    = 32;
   localparam int unsigned MEM   = 4;
   localparam int unsigned NR    = 2;
   localparam int unsigned OCC_W = $clog2(MEM + 1);

   localparam logic [1:0] S_OK = 2'd0, S_MISS = 2'd1, S_DUP = 2'd2, S_FULL = 2'd3;
   localparam logic [1:0] O_RD = 2'd0, O_WR = 2'd1, O_DEL = 2'd2, O_RSV = 2'd3;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NR-1:0]           req_valid;
   logic [NR-1:0]           req_ready;
   logic [NR-1:0][1:0]      req_op;
   logic [NR-1:0][KW-1:0]   req_key;
   logic [NR-1:0][DW-1:0]   req_data;
   logic [NR-1:0]           resp_valid;
   logic [1:0]              resp_status;
   logic [DW-1:0]           resp_data;
   logic [OCC_W-1:0]        occupancy;
   logic                    cache_cs, cache_we, cache_read_en, cache_del;
   logic [KW-1:0]           cache_key_write, cache_key_read;
   logic [DW-1:0]           cache_data_in, cache_data_out;
   logic                    cache_valid;
   logic [1:0]              cache_error;
   logic                    err_inject;
`ifdef HASH_CASH_CTRL_STATS_EN
   logic                    stat_clear = 1'b0;
   logic [31:0]             stat_hits, stat_misses;
`endif

   always #5 clk = ~clk;

   hash_cash_ctrl #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .MEM_SIZE(MEM), .NUM_REQ(NR)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_key         (req_key),
      .req_data        (req_data),
      .resp_valid      (resp_valid),
      .resp_status     (resp_status),
      .resp_data       (resp_data),
      .occupancy       (occupancy),
      .cache_cs        (cache_cs),
      .cache_we        (cache_we),
      .cache_read_en   (cache_read_en),
      .cache_del       (cache_del),
      .cache_key_write (cache_key_write),
      .cache_key_read  (cache_key_read),
      .cache_data_in   (cache_data_in),
      .cache_data_out  (cache_data_out),
      .cache_valid     (cache_valid),
      .cache_error     (cache_error)
`ifdef HASH_CASH_CTRL_STATS_EN
      ,
      .stat_clear      (stat_clear),
      .stat_hits       (stat_hits),
      .stat_misses     (stat_misses)
`endif
   );

   // Behavioural hash_cash: registered lookup result, holds outputs while deselected
   logic [DW-1:0] cache_mem [logic [KW-1:0]];
   assign cache_error = {1'b0, err_inject & cache_cs & cache_we};

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cache_mem.delete();
         cache_valid    <= 1'b0;
         cache_data_out <= '0;
      end else begin
         if (cache_cs && cache_read_en) begin
            cache_valid    <= cache_mem.exists(cache_key_read);
            cache_data_out <= cache_mem.exists(cache_key_read) ? cache_mem[cache_key_read] : '0;
         end
         if (cache_cs && cache_we && !cache_error[0]) cache_mem[cache_key_write] = cache_data_in;
         if (cache_cs && cache_del) cache_mem.delete(cache_key_write);
      end
   end

   int we_cnt = 0, del_cnt = 0, resp_cnt = 0;
   always @(posedge clk) begin
      if (cache_cs && cache_we) we_cnt <= we_cnt + 1;
      if (cache_cs && cache_del) del_cnt <= del_cnt + 1;
      if (|resp_valid) resp_cnt <= resp_cnt + 1;
   end

   logic [DW-1:0] ref_map [logic [KW-1:0]];
   int ref_ptr = 0;
   int n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_req(input int r, input logic [1:0] op, input logic [KW-1:0] k, input logic [DW-1:0] d);
      req_valid[r] = 1'b1;
      req_op[r]    = op;
      req_key[r]   = k;
      req_data[r]  = d;
   endtask

   // One arbitrated transaction, predicted from the key/value rules
   task automatic step(input bit keep_busy);
      int w, cnt, lat, exp_lat, exp_we, exp_del, we0, del0;
      logic [1:0]    op, st;
      logic [KW-1:0] k;
      logic [DW-1:0] rd;
      #1;
      cnt = 0;
      while (req_ready == '0 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      if (req_ready == '0) begin
         check("grant_timeout", 64'(req_ready), 64'(1));
         return;
      end
      check("idle_resp", {resp_valid, resp_status, resp_data}, 64'(0));
      check("idle_key", 64'(cache_key_read), 64'(0));
      w = -1;
      for (int i = 0; i < int'(NR); i++) begin
         int c;
         c = (ref_ptr + i) % int'(NR);
         if (w < 0 && req_valid[c]) w = c;
      end
      if (w < 0) begin
         check("winner_exists", 64'(0), 64'(1));
         w = 0;
      end
      check("req_ready", 64'(req_ready), 64'(1) << w);
      ref_ptr = (w + 1) % int'(NR);
      op = req_op[w];
      k  = req_key[w];
      rd = '0; exp_lat = 3; exp_we = 0; exp_del = 0;
      case (op)
         O_WR: begin
            if (ref_map.exists(k))            st = S_DUP;
            else if (ref_map.num() == int'(MEM)) st = S_FULL;
            else begin
               exp_lat = 4; exp_we = 1;
               if (err_inject) st = S_DUP;
               else begin st = S_OK; ref_map[k] = req_data[w]; end
            end
         end
         O_DEL: begin
            if (ref_map.exists(k)) begin
               st = S_OK; exp_lat = 4; exp_del = 1; ref_map.delete(k);
            end else st = S_MISS;
         end
         default: begin
            if (ref_map.exists(k)) begin st = S_OK; rd = ref_map[k]; end
            else st = S_MISS;
         end
      endcase
      we0 = we_cnt; del0 = del_cnt;
      @(posedge clk);
      #1;
      req_valid[w] = 1'b0;
      if (keep_busy) set_req(w, O_RD, KW'($urandom_range(0, 7)), '0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (resp_valid == '0 && lat < 12);
      check("latency", 64'(lat), 64'(exp_lat));
      check("resp_owner", 64'(resp_valid), 64'(1) << w);
      check("resp_status", 64'(resp_status), 64'(st));
      check("resp_data", 64'(resp_data), 64'(rd));
      check("occupancy", 64'(occupancy), 64'(ref_map.num()));
      check("we_pulses", 64'(we_cnt - we0), 64'(exp_we));
      check("del_pulses", 64'(del_cnt - del0), 64'(exp_del));
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      req_valid = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ref_map.delete();
      ref_ptr = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int r0;
      reset = 1'b1; req_valid = '0; req_op = '0; req_key = '0; req_data = '0; err_inject = 1'b0;
      repeat (3) @(negedge clk);
      req_valid = '1;
      #1;
      check("rst_ready", 64'(req_ready), 64'(0));
      check("rst_resp", {resp_valid, resp_status, resp_data}, 64'(0));
      check("rst_occ", 64'(occupancy), 64'(0));
      check("rst_ctl", {cache_cs, cache_we, cache_read_en, cache_del}, 64'(0));
      check("rst_keys", {cache_key_read, cache_key_write}, 64'(0));
      req_valid = '0;
      @(negedge clk);
      reset = 1'b0;

      set_req(0, O_WR, 32'h10, 32'hAB); step(0);
      set_req(0, O_RD, 32'h10, 32'h0);  step(0);
      set_req(0, O_WR, 32'h10, 32'h55); step(0);
      set_req(0, O_RD, 32'h99, 32'h0);  step(0);
      set_req(0, O_DEL, 32'h10, 32'h0); step(0);
      set_req(0, O_DEL, 32'h10, 32'h0); step(0);
      for (int k = 1; k <= 5; k++) begin
         set_req(0, O_WR, KW'(k), DW'(32'h100 + k));
         step(0);
      end
      set_req(1, O_RSV, 32'h3, 32'h0); step(0);
      set_req(1, O_DEL, 32'h1, 32'h0); step(0);
      err_inject = 1'b1;
      set_req(0, O_WR, 32'h20, 32'hBEEF); step(0);
      err_inject = 1'b0;
      set_req(0, O_RD, 32'h20, 32'h0); step(0);

      set_req(0, O_RD, 32'h2, 32'h0);
      set_req(1, O_RD, 32'h4, 32'h0);
      repeat (6) step(1);
      req_valid = '0;

      repeat (150) begin
         for (int r = 0; r < int'(NR); r++)
            if (!req_valid[r] && $urandom_range(0, 1) == 1)
               set_req(r, 2'($urandom_range(0, 3)), KW'($urandom_range(0, 7)), $urandom);
         if (req_valid == '0) set_req(0, 2'($urandom_range(0, 3)), KW'($urandom_range(0, 7)), $urandom);
         step(0);
      end
      req_valid = '0;

      // Reset while the write commit is on the cache interface
      pulse_reset();
      set_req(0, O_WR, 32'h77, 32'h1234);
      #1;
      check("pre_commit_ready", 64'(req_ready), 64'(1));
      @(posedge clk);
      #1;
      req_valid = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("in_commit_we", 64'(cache_we), 64'(1));
      r0 = resp_cnt;
      reset = 1'b1;
      #1;
      check("mid_rst_ctl", {req_ready, resp_valid, cache_cs, cache_we, cache_read_en, cache_del}, 64'(0));
      check("mid_rst_data", {resp_status, resp_data, cache_data_in}, 64'(0));
      check("mid_rst_key", {cache_key_read, cache_key_write}, 64'(0));
      check("mid_rst_occ", 64'(occupancy), 64'(0));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ref_map.delete();
      ref_ptr = 0;
      @(negedge clk);
      check("no_resp_after_rst", 64'(resp_cnt - r0), 64'(0));
      set_req(0, O_RD, 32'h77, 32'h0);    step(0);
      set_req(1, O_WR, 32'h77, 32'h4321); step(0);
      set_req(0, O_RD, 32'h77, 32'h0);    step(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
